// File: rtl/operand_fwd_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : operand_fwd_stage_pkg                                   |
// | Brief  : Shared constants and types for the ID-stage operand     |
// |          forwarding / ID-EX pipeline register slice.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package operand_fwd_stage_pkg;

  // Datapath and control-bundle widths shared with decode
  localparam int DW_DEF = 32;
  localparam int CW_DEF = 16;

  // Per-operand redirect select encodings; 2'b11 resolves to EX (newer producer)
  localparam logic [1:0] RED_RF  = 2'b00;
  localparam logic [1:0] RED_EX  = 2'b01;
  localparam logic [1:0] RED_MEM = 2'b10;

  // Control bundle carried by a bubble: no side effects downstream
  localparam logic [CW_DEF-1:0] CTRL_BUBBLE = '0;

  // What the ID/EX slot does this cycle, in priority order
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_LOCK  = 2'd2,
    ACT_LOAD  = 2'd3
  } cycle_act_e;

endpackage : operand_fwd_stage_pkg
`default_nettype wire

// File: rtl/operand_fwd_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : operand_fwd_stage_if                                    |
// | Brief  : ID-side inputs and ID/EX register outputs of the        |
// |          operand forwarding stage, grouped as one bundle.        |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface operand_fwd_stage_if
  import operand_fwd_stage_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int CW    = CW_DEF,
  parameter int CNT_W = 32
) ();

  // Interlock / redirect controls from the forwarding unit
  logic          lock;
  logic [1:0]    Red_R1;
  logic [1:0]    Red_R2;
  logic          flush;
  logic          halt;

  // ID-stage operands and fields
  logic [DW-1:0] rf_R1data;
  logic [DW-1:0] rf_R2data;
  logic [DW-1:0] EX_fwd;
  logic [DW-1:0] MEM_fwd;
  logic [CW-1:0] ID_ctrl;
  logic [DW-1:0] ID_pc;
  logic [DW-1:0] ID_imm;
  logic [4:0]    ID_RW;
  logic          ID_We;

  // Front-end enables and ID/EX register
  logic          pc_en;
  logic          ifid_en;
  logic [DW-1:0] EX_A;
  logic [DW-1:0] EX_B;
  logic [DW-1:0] EX_imm;
  logic [DW-1:0] EX_pc;
  logic [CW-1:0] EX_ctrl;
  logic [4:0]    EX_RW;
  logic          EX_We;
  logic          EX_valid;

  // Performance counters and watchdog
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             lock_err;

  // Driver of the ID-side signals
  modport master (
    output lock, Red_R1, Red_R2, flush, halt,
    output rf_R1data, rf_R2data, EX_fwd, MEM_fwd,
    output ID_ctrl, ID_pc, ID_imm, ID_RW, ID_We,
    input  pc_en, ifid_en,
    input  EX_A, EX_B, EX_imm, EX_pc, EX_ctrl, EX_RW, EX_We, EX_valid,
    input  stall_cnt, flush_cnt, lock_err
  );

  // The stage itself
  modport slave (
    input  lock, Red_R1, Red_R2, flush, halt,
    input  rf_R1data, rf_R2data, EX_fwd, MEM_fwd,
    input  ID_ctrl, ID_pc, ID_imm, ID_RW, ID_We,
    output pc_en, ifid_en,
    output EX_A, EX_B, EX_imm, EX_pc, EX_ctrl, EX_RW, EX_We, EX_valid,
    output stall_cnt, flush_cnt, lock_err
  );

endinterface : operand_fwd_stage_if
`default_nettype wire

// File: rtl/operand_fwd_stage_fwd_mux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : fwd_mux                                                 |
// | Brief  : Combinational operand source select: register file,     |
// |          EX result or MEM result. EX wins when both are flagged. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module fwd_mux
  import operand_fwd_stage_pkg::*;
#(
  parameter int W = DW_DEF
) (
  input  wire logic [1:0]   i_sel,
  input  wire logic [W-1:0] i_rf,
  input  wire logic [W-1:0] i_ex,
  input  wire logic [W-1:0] i_mem,
  output logic      [W-1:0] o_y
);

  // Pick the operand source; both-bits-set means EX, the youngest producer
  always_comb begin
    o_y = i_rf;
    case (i_sel)
      RED_RF:  o_y = i_rf;
      RED_MEM: o_y = i_mem;
      default: o_y = i_ex;
    endcase
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/operand_fwd_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : operand_fwd_stage                                       |
// | Brief  : Builds the ID/EX pipeline register from forwarded       |
// |          operands, inserts bubbles on lock/flush, drives the     |
// |          front-end enables, counts stalls/flushes and flags      |
// |          over-long interlocks.                                   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int CW       = CW_DEF,
  parameter int CNT_W    = 32,
  parameter int LOCK_MAX = 2
) (
  input wire logic           clk,
  input wire logic           rst_n,
  operand_fwd_stage_if.slave bus
);

  // Run counter only needs to reach LOCK_MAX+1, where it saturates
  localparam int              RUN_W      = $clog2(LOCK_MAX + 2);
  localparam logic [RUN_W-1:0] C_RUN_SAT  = RUN_W'(LOCK_MAX + 1);
  localparam logic [RUN_W-1:0] C_LOCK_MAX = RUN_W'(LOCK_MAX);

  cycle_act_e       w_act;
  logic             w_front_en;
  logic [DW-1:0]    w_op_a;
  logic [DW-1:0]    w_op_b;
  logic [RUN_W-1:0] w_run_nxt;

  logic [DW-1:0]    r_ex_a;
  logic [DW-1:0]    r_ex_b;
  logic [DW-1:0]    r_ex_imm;
  logic [DW-1:0]    r_ex_pc;
  logic [CW-1:0]    r_ex_ctrl;
  logic [4:0]       r_ex_rw;
  logic             r_ex_we;
  logic             r_ex_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [RUN_W-1:0] r_lock_run;
  logic             r_lock_err;

  fwd_mux #(.W(DW)) u_mux_a (
    .i_sel (bus.Red_R1),
    .i_rf  (bus.rf_R1data),
    .i_ex  (bus.EX_fwd),
    .i_mem (bus.MEM_fwd),
    .o_y   (w_op_a)
  );

  fwd_mux #(.W(DW)) u_mux_b (
    .i_sel (bus.Red_R2),
    .i_rf  (bus.rf_R2data),
    .i_ex  (bus.EX_fwd),
    .i_mem (bus.MEM_fwd),
    .o_y   (w_op_b)
  );

  // Resolve this cycle's action; flush beats lock since a lock on a killed
  // wrong-path instruction is meaningless
  always_comb begin
    w_act = ACT_LOAD;
    if (bus.halt)       w_act = ACT_HOLD;
    else if (bus.flush) w_act = ACT_FLUSH;
    else if (bus.lock)  w_act = ACT_LOCK;
  end

  // Front end advances on a normal load or a flush; held in reset
  assign w_front_en  = rst_n && ((w_act == ACT_LOAD) || (w_act == ACT_FLUSH));
  assign bus.pc_en   = w_front_en;
  assign bus.ifid_en = w_front_en;

  // Consecutive-lock run length; halt freezes it, a lock-free cycle clears it
  always_comb begin
    w_run_nxt = r_lock_run;
    if (!bus.halt) begin
      if (!bus.lock)                   w_run_nxt = '0;
      else if (r_lock_run != C_RUN_SAT) w_run_nxt = r_lock_run + RUN_W'(1);
    end
  end

  // ID/EX pipeline register: load, bubble or hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_a     <= '0;
      r_ex_b     <= '0;
      r_ex_imm   <= '0;
      r_ex_pc    <= '0;
      r_ex_ctrl  <= '0;
      r_ex_rw    <= '0;
      r_ex_we    <= 1'b0;
      r_ex_valid <= 1'b0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_LOCK: begin
          r_ex_a     <= '0;
          r_ex_b     <= '0;
          r_ex_imm   <= '0;
          r_ex_pc    <= '0;
          r_ex_ctrl  <= CW'(CTRL_BUBBLE);
          r_ex_rw    <= '0;
          r_ex_we    <= 1'b0;
          r_ex_valid <= 1'b0;
        end
        ACT_LOAD: begin
          r_ex_a     <= w_op_a;
          r_ex_b     <= w_op_b;
          r_ex_imm   <= bus.ID_imm;
          r_ex_pc    <= bus.ID_pc;
          r_ex_ctrl  <= bus.ID_ctrl;
          r_ex_rw    <= bus.ID_RW;
          r_ex_we    <= bus.ID_We;
          r_ex_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating stall/flush counters and the sticky lock watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_lock_run  <= '0;
      r_lock_err  <= 1'b0;
    end else begin
      r_lock_run <= w_run_nxt;
      if (!bus.halt && (w_run_nxt > C_LOCK_MAX)) r_lock_err <= 1'b1;
      if ((w_act == ACT_FLUSH) && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if ((w_act == ACT_LOCK) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.EX_A      = r_ex_a;
  assign bus.EX_B      = r_ex_b;
  assign bus.EX_imm    = r_ex_imm;
  assign bus.EX_pc     = r_ex_pc;
  assign bus.EX_ctrl   = r_ex_ctrl;
  assign bus.EX_RW     = r_ex_rw;
  assign bus.EX_We     = r_ex_we;
  assign bus.EX_valid  = r_ex_valid;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  assign bus.lock_err  = r_lock_err;

endmodule : operand_fwd_stage
`default_nettype wire

// File: tb/tb_operand_fwd_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_operand_fwd_stage                                    |
// | Brief  : Self-checking bench for operand_fwd_stage (4-bit        |
// |          counters so saturation is reachable quickly).           |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_operand_fwd_stage;
  import operand_fwd_stage_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam int CNT_W = 4;
  localparam int LOCK_MAX = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  operand_fwd_stage_if #(.DW(DW), .CW(CW), .CNT_W(CNT_W)) bus ();

  operand_fwd_stage #(.DW(DW), .CW(CW), .CNT_W(CNT_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  r1, r2;
    logic [31:0] rf1, rf2, imm, pc;
    logic [15:0] ctrl;
    logic [4:0]  rw;
    logic        we;
    logic [31:0] exp_a, exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a, b, imm, pc;
    logic [15:0] ctrl;
    logic [4:0]  rw;
    logic        we, valid;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  exp_t last_ex;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e.a = '0; e.b = '0; e.imm = '0; e.pc = '0;
    e.ctrl = '0; e.rw = '0; e.we = 1'b0; e.valid = 1'b0;
    return e;
  endfunction

  function automatic exp_t load_of(input vec_t v);
    exp_t e;
    e.a = v.exp_a; e.b = v.exp_b; e.imm = v.imm; e.pc = v.pc;
    e.ctrl = v.ctrl; e.rw = v.rw; e.we = v.we; e.valid = 1'b1;
    return e;
  endfunction

  task automatic apply(input vec_t v, input logic lk, input logic fl, input logic hl);
    bus.Red_R1 = v.r1;       bus.Red_R2 = v.r2;
    bus.rf_R1data = v.rf1;   bus.rf_R2data = v.rf2;
    bus.ID_imm = v.imm;      bus.ID_pc = v.pc;
    bus.ID_ctrl = v.ctrl;    bus.ID_RW = v.rw;   bus.ID_We = v.we;
    bus.lock = lk;           bus.flush = fl;     bus.halt = hl;
  endtask

  // Push expected slot content, check the combinational enables, clock,
  // then pop and compare against what the DUT registered
  task automatic cycle(input string tag, input logic exp_en, input exp_t e);
    exp_t g;
    sb.push_back(e);
    #1;
    chk({tag, " pc_en"}, 64'(bus.pc_en), 64'(exp_en));
    chk({tag, " ifid_en"}, 64'(bus.ifid_en), 64'(exp_en));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      g = sb.pop_front();
      chk({tag, " EX_A"},     64'(bus.EX_A),     64'(g.a));
      chk({tag, " EX_B"},     64'(bus.EX_B),     64'(g.b));
      chk({tag, " EX_imm"},   64'(bus.EX_imm),   64'(g.imm));
      chk({tag, " EX_pc"},    64'(bus.EX_pc),    64'(g.pc));
      chk({tag, " EX_ctrl"},  64'(bus.EX_ctrl),  64'(g.ctrl));
      chk({tag, " EX_RW"},    64'(bus.EX_RW),    64'(g.rw));
      chk({tag, " EX_We"},    64'(bus.EX_We),    64'(g.we));
      chk({tag, " EX_valid"}, 64'(bus.EX_valid), 64'(g.valid));
      last_ex = g;
    end
  endtask

  // Reset applied while a lock is pending; everything must come back clean
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.lock = 1'b1; bus.flush = 1'b0; bus.halt = 1'b0;
    #1;
    chk({tag, " pc_en in reset"}, 64'(bus.pc_en), 64'd0);
    chk({tag, " ifid_en in reset"}, 64'(bus.ifid_en), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " EX_valid"}, 64'(bus.EX_valid), 64'd0);
    chk({tag, " EX_A"}, 64'(bus.EX_A), 64'd0);
    chk({tag, " EX_ctrl"}, 64'(bus.EX_ctrl), 64'd0);
    chk({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'd0);
    chk({tag, " flush_cnt"}, 64'(bus.flush_cnt), 64'd0);
    chk({tag, " lock_err"}, 64'(bus.lock_err), 64'd0);
    rst_n = 1'b1;
    bus.lock = 1'b0;
    sb.delete();
    last_ex = bubble();
  endtask

  initial begin
    vecs[0] = '{r1:2'b00, r2:2'b00, rf1:32'h11,   rf2:32'h22,   imm:32'h7,   pc:32'h100,
                ctrl:16'h1234, rw:5'd5,  we:1'b1, exp_a:32'h11,   exp_b:32'h22};
    vecs[1] = '{r1:2'b01, r2:2'b10, rf1:32'h11,   rf2:32'h22,   imm:32'h8,   pc:32'h104,
                ctrl:16'h00F0, rw:5'd9,  we:1'b1, exp_a:32'hAAAA, exp_b:32'hBBBB};
    vecs[2] = '{r1:2'b11, r2:2'b11, rf1:32'h33,   rf2:32'h44,   imm:32'h9,   pc:32'h108,
                ctrl:16'hFFFF, rw:5'd31, we:1'b0, exp_a:32'hAAAA, exp_b:32'hAAAA};
    vecs[3] = '{r1:2'b10, r2:2'b01, rf1:32'h55,   rf2:32'h66,   imm:32'hA,   pc:32'h10C,
                ctrl:16'h0001, rw:5'd1,  we:1'b1, exp_a:32'hBBBB, exp_b:32'hAAAA};
    vecs[4] = '{r1:2'b00, r2:2'b11, rf1:32'h5555, rf2:32'h6666, imm:32'hFFFF_FFFF, pc:32'h110,
                ctrl:16'h8000, rw:5'd0, we:1'b0, exp_a:32'h5555, exp_b:32'hAAAA};

    bus.EX_fwd = 32'hAAAA;
    bus.MEM_fwd = 32'hBBBB;
    apply(vecs[0], 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Main table: operand selection under several source patterns
    for (int i = 0; i < 5; i++) begin
      apply(vecs[i], 1'b0, 1'b0, 1'b0);
      cycle($sformatf("vec%0d", i), 1'b1, load_of(vecs[i]));
    end

    // Single-cycle lock: bubble, front end frozen, then the held instruction loads
    apply(vecs[0], 1'b1, 1'b0, 1'b0);
    cycle("lock", 1'b0, bubble());
    chk("lock stall_cnt", 64'(bus.stall_cnt), 64'd1);
    apply(vecs[0], 1'b0, 1'b0, 1'b0);
    cycle("after lock", 1'b1, load_of(vecs[0]));

    // Lock together with flush: flush wins, only flush_cnt moves
    do_reset("reset2");
    apply(vecs[1], 1'b1, 1'b1, 1'b0);
    cycle("lock+flush", 1'b1, bubble());
    chk("lock+flush flush_cnt", 64'(bus.flush_cnt), 64'd1);
    chk("lock+flush stall_cnt", 64'(bus.stall_cnt), 64'd0);
    apply(vecs[1], 1'b0, 1'b0, 1'b0);
    cycle("pre-halt load", 1'b1, load_of(vecs[1]));

    // Halt for 3 cycles with lock/flush noise: everything holds
    for (int i = 0; i < 3; i++) begin
      apply(vecs[i + 2], i[0], ~i[0], 1'b1);
      cycle($sformatf("halt%0d", i), 1'b0, last_ex);
      chk($sformatf("halt%0d flush_cnt", i), 64'(bus.flush_cnt), 64'd1);
      chk($sformatf("halt%0d stall_cnt", i), 64'(bus.stall_cnt), 64'd0);
    end

    // Watchdog: two 2-cycle lock runs separated by a free cycle stay legal
    do_reset("reset3");
    for (int i = 0; i < 2; i++) begin
      apply(vecs[0], 1'b1, 1'b0, 1'b0);
      cycle("run1", 1'b0, bubble());
    end
    apply(vecs[0], 1'b0, 1'b0, 1'b0);
    cycle("gap", 1'b1, load_of(vecs[0]));
    for (int i = 0; i < 2; i++) begin
      apply(vecs[0], 1'b1, 1'b0, 1'b0);
      cycle("run2", 1'b0, bubble());
    end
    chk("wd after 2-run lock_err", 64'(bus.lock_err), 64'd0);
    chk("wd stall_cnt=4", 64'(bus.stall_cnt), 64'd4);

    // Halt mid-run must hold the run counter, not clear it
    apply(vecs[0], 1'b0, 1'b0, 1'b1);
    cycle("wd halt", 1'b0, bubble());
    chk("wd halt lock_err", 64'(bus.lock_err), 64'd0);

    // Third consecutive lock cycle trips the watchdog
    apply(vecs[0], 1'b1, 1'b0, 1'b0);
    cycle("run3", 1'b0, bubble());
    chk("wd trip lock_err", 64'(bus.lock_err), 64'd1);
    chk("wd stall_cnt=5", 64'(bus.stall_cnt), 64'd5);

    // Drive the stall counter to all-ones and one beyond
    for (int i = 0; i < 11; i++) begin
      apply(vecs[0], 1'b1, 1'b0, 1'b0);
      cycle("sat", 1'b0, bubble());
    end
    chk("stall_cnt at max", 64'(bus.stall_cnt), 64'hF);
    apply(vecs[0], 1'b1, 1'b0, 1'b0);
    cycle("sat+1", 1'b0, bubble());
    chk("stall_cnt saturated", 64'(bus.stall_cnt), 64'hF);

    // Error is sticky across lock-free cycles
    apply(vecs[2], 1'b0, 1'b0, 1'b0);
    cycle("sticky", 1'b1, load_of(vecs[2]));
    chk("lock_err sticky", 64'(bus.lock_err), 64'd1);

    // Reset clears it
    do_reset("reset4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_operand_fwd_stage
`default_nettype wire
